tick_stopwatch: RTL and testbench
=================================

# tick_stopwatch

BCD stopwatch that consumes the one-cycle `tick_in` strobe produced by the frequency divider (`cnt_div`) and counts those ticks while running. It sits directly downstream of the divider and upstream of the seven-segment display driver. A start/stop button toggles counting, and a clear input zeroes the count. The block presents the count as packed BCD digits plus status flags.

## Interface
- `DIGITS`, default 4: number of BCD decades; count range is 0 to 10^DIGITS−1.
- `clk_in`, input, 1: system clock; the only clock in the block.
- `rst_n`, input, 1: reset, synchronous and active-low; sampled on the rising edge of `clk_in`.
- `tick_in`, input, 1: count-enable strobe from `cnt_div`; one `clk_in` cycle wide.
- `start_stop`, input, 1: start/stop button level, already synchronized and debounced; only its rising edge acts.
- `clear`, input, 1: level-sensitive clear.
- `bcd_out`, output, 4*DIGITS: packed BCD count; bits [3:0] hold the least significant digit.
- `running`, output, 1: high while the state is RUN.
- `ovf`, output, 1: one-cycle pulse when the count wraps from all 9s to 0.

## Operation
- Edge detection:
  - `ss_prev` register; `ss_edge = start_stop & ~ss_prev`.
  - `ss_prev` updates every cycle, including cycles where `clear` is high.
- State machine with three states:
  - IDLE: count is 0.
    - `ss_edge` → RUN.
  - RUN:
    - `ss_edge` → PAUSE.
    - Each cycle with `tick_in`=1 increments the count.
  - PAUSE: count is held.
    - `ss_edge` → RUN.
  - `clear`=1 in any state → IDLE with count 0. `clear` has priority over `ss_edge` and over `tick_in`; an edge arriving in the same cycle is discarded.
- Counting rule: the increment decision uses the registered (current) state, not the next state.
  - A tick in the same cycle as the RUN→PAUSE edge is counted.
  - A tick in the same cycle as the IDLE→RUN or PAUSE→RUN edge is not counted.
- Arithmetic: a ripple of decade counters.
  - Digit k increments when enable is set and all lower digits are 9.
  - A digit at 9 wraps to 0.
  - Digit values are always 0–9; codes 10–15 never appear.
- Wrap: when the count is all 9s and a counted tick arrives, the count becomes 0, `ovf`=1 for exactly that cycle, and the state stays RUN.
- `running` is decoded combinationally from the state register.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State = IDLE, `bcd_out`=0, `ovf`=0, `running`=0.
  - `ss_prev`=1, so a button already held through reset does not start the count.
- Reset mid-count overrides everything in that cycle, including a tick and an edge.
- Latency:
  - `bcd_out` changes on the edge after the cycle in which `tick_in`=1 is sampled.
  - `running` changes on the edge after the cycle in which `ss_edge` is sampled.
  - `clear` takes effect in the same manner as these.
- `ovf` is registered and asserts on the same edge on which `bcd_out` becomes 0.
- Back-to-back ticks (`tick_in` held high, e.g. `DIV_CNT`=1) count once per cycle.
- A held `start_stop` produces exactly one edge.

## Structure
- Shared package/header `stopwatch_pkg`:
  - State encodings: `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_PAUSE`=2'd2. Encoding 2'd3 decodes to IDLE.
  - Constant `BCD_MAX`=4'd9.
- Sub-module `bcd_digit`:
  - Ports: `clk_in`, `rst_n`, `clr`, `en`, `q[3:0]`, `carry` (`carry = en & (q==9)`).
  - Instantiated `DIGITS` times in a generate loop; `en` of digit k is the carry of digit k−1.
  - Digit 0 `en` = `tick_in & (state==ST_RUN) & ~clear`.
- Top level holds the FSM, the edge detector and the `ovf` register.

## Test plan
1. Reset with `start_stop`=1 held, then 5 ticks → `bcd_out`=0, `running`=0 throughout.
2. Start from IDLE, 12 ticks, stop, 3 ticks, start, 1 tick → `bcd_out`=16'h0013, `running`=1.
3. `DIGITS`=2, count preset to 99 via 99 ticks, one more tick → `bcd_out`=8'h00, `ovf` high for exactly 1 cycle, `running`=1.
4. Same-cycle events:
   - Stop edge with tick at count 7 → 8, then PAUSE.
   - Start edge with tick from PAUSE at 8 → stays 8.
5. `clear` together with `ss_edge` and `tick_in` while in RUN at count 0x0042 → next cycle IDLE, `bcd_out`=0, `running`=0; no start occurs.
6. `rst_n` pulsed low for 1 cycle in RUN at count 0x0250 with a tick present → IDLE, `bcd_out`=0, `ovf`=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the tick-driven BCD stopwatch: FSM encoding and digit limit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch count: 0..9 counter with clear and ripple carry-out.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (en) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en & (q_q == BCD_MAX);

endmodule

// File: rtl/tick_stopwatch.sv
// Start/stop/clear BCD stopwatch counting divider ticks; holds the FSM, button edge
// detector and the registered wrap pulse around a ripple of bcd_digit decades.
module tick_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  tick_in,
    input  logic                  start_stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  ovf
);

    state_e state_q, state_d;
    logic   ss_prev_q;
    logic   ovf_q;
    logic   ss_edge;
    logic [DIGITS:0] en;

    assign ss_edge = start_stop & ~ss_prev_q;

    // Counting keys off the registered state, so a tick on a start edge is dropped
    // while a tick on a stop edge still lands.
    assign en[0] = tick_in & (state_q == ST_RUN) & ~clear;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .clr    (clear),
            .en     (en[k]),
            .q      (bcd_out[4*k +: 4]),
            .carry  (en[k+1])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (ss_edge) state_d = ST_PAUSE;
            ST_PAUSE: if (ss_edge) state_d = ST_RUN;
            default:  if (ss_edge) state_d = ST_RUN;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ss_prev_q <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ss_prev_q <= start_stop;
            ovf_q     <= en[DIGITS];
        end
    end

    assign running = (state_q == ST_RUN);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: a 4-digit and a 2-digit instance share stimulus and are
// compared against an integer-count reference model.
module tb_tick_stopwatch;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        start_stop = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] bcd4;
    logic [7:0]  bcd2;
    logic        run4, run2, ovf4, ovf2;

    int total = 0;
    int bad = 0;

    // reference model: mode 0=idle 1=run 2=pause, counts as plain integers
    int m_mode = 0;
    int m_cnt4 = 0;
    int m_cnt2 = 0;
    bit m_ovf4 = 0;
    bit m_ovf2 = 0;
    bit m_ssprev = 1;

    always #5 clk_in = ~clk_in;

    tick_stopwatch #(.DIGITS(4)) dut4 (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .bcd_out(bcd4), .running(run4), .ovf(ovf4)
    );

    tick_stopwatch #(.DIGITS(2)) dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .bcd_out(bcd2), .running(run2), .ovf(ovf2)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // one clock cycle: drive at negedge, model the sampling edge, return at next negedge
    task automatic cyc(input bit t, input bit ss, input bit clr, input bit rn);
        bit edge_seen, counted;
        tick_in = t; start_stop = ss; clear = clr; rst_n = rn;
        @(posedge clk_in);
        if (!rn) begin
            m_mode = 0; m_cnt4 = 0; m_cnt2 = 0; m_ovf4 = 0; m_ovf2 = 0; m_ssprev = 1;
        end else begin
            edge_seen = ss && !m_ssprev;
            m_ssprev = ss;
            if (clr) begin
                m_mode = 0; m_cnt4 = 0; m_cnt2 = 0; m_ovf4 = 0; m_ovf2 = 0;
            end else begin
                counted = t && (m_mode == 1);
                m_ovf4 = counted && (m_cnt4 == 9999);
                m_ovf2 = counted && (m_cnt2 == 99);
                if (counted) begin
                    m_cnt4 = (m_cnt4 + 1) % 10000;
                    m_cnt2 = (m_cnt2 + 1) % 100;
                end
                if (edge_seen) m_mode = (m_mode == 1) ? 2 : 1;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic restart();
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        total++;
        if (bcd4 !== 16'h0000 || run4 !== 1'b0 || ovf4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: bcd=%h run=%b ovf=%b want 0000/0/0", bcd4, run4, ovf4);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 1);
            total++;
            if (bcd4 !== 16'h0000 || run4 !== 1'b0) begin
                bad++;
                $display("FAIL held_button_after_reset[%0d]: bcd=%h run=%b want 0000/0", i, bcd4, run4);
            end
        end
    endtask

    task automatic test_count_pause();
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        total++;
        if (run4 !== 1'b1) begin
            bad++;
            $display("FAIL held_start_one_edge: run=%b want 1", run4);
        end
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1);
        total++;
        if (bcd4 !== 16'h0012 || run4 !== 1'b0) begin
            bad++;
            $display("FAIL pause_after_12: bcd=%h run=%b want 0012/0", bcd4, run4);
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(1, 0, 0, 1);
        total++;
        if (bcd4 !== 16'h0013 || run4 !== 1'b1) begin
            bad++;
            $display("FAIL resume_count: bcd=%h run=%b want 0013/1", bcd4, run4);
        end
    endtask

    task automatic test_wrap();
        restart();
        for (int i = 0; i < 99; i++) cyc(1, 0, 0, 1);
        total++;
        if (bcd2 !== 8'h99 || ovf2 !== 1'b0) begin
            bad++;
            $display("FAIL preset_99: bcd2=%h ovf2=%b want 99/0", bcd2, ovf2);
        end
        cyc(1, 0, 0, 1);
        total++;
        if (bcd2 !== 8'h00 || ovf2 !== 1'b1 || run2 !== 1'b1) begin
            bad++;
            $display("FAIL wrap: bcd2=%h ovf2=%b run2=%b want 00/1/1", bcd2, ovf2, run2);
        end
        total++;
        if (bcd4 !== 16'h0100 || ovf4 !== 1'b0) begin
            bad++;
            $display("FAIL carry_into_hundreds: bcd4=%h ovf4=%b want 0100/0", bcd4, ovf4);
        end
        cyc(0, 0, 0, 1);
        total++;
        if (ovf2 !== 1'b0 || bcd2 !== 8'h00) begin
            bad++;
            $display("FAIL ovf_one_cycle: ovf2=%b bcd2=%h want 0/00", ovf2, bcd2);
        end
    endtask

    task automatic test_same_cycle();
        restart();
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 1);
        total++;
        if (bcd4 !== 16'h0008 || run4 !== 1'b0) begin
            bad++;
            $display("FAIL stop_with_tick: bcd=%h run=%b want 0008/0", bcd4, run4);
        end
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 1);
        total++;
        if (bcd4 !== 16'h0008 || run4 !== 1'b1) begin
            bad++;
            $display("FAIL start_with_tick: bcd=%h run=%b want 0008/1", bcd4, run4);
        end
        cyc(1, 1, 0, 1);
        total++;
        if (bcd4 !== 16'h0009) begin
            bad++;
            $display("FAIL tick_after_start: bcd=%h want 0009", bcd4);
        end
    endtask

    task automatic test_clear_priority();
        restart();
        for (int i = 0; i < 42; i++) cyc(1, 0, 0, 1);
        cyc(1, 1, 1, 1);
        total++;
        if (bcd4 !== 16'h0000 || run4 !== 1'b0 || ovf4 !== 1'b0) begin
            bad++;
            $display("FAIL clear_priority: bcd=%h run=%b ovf=%b want 0000/0/0", bcd4, run4, ovf4);
        end
        cyc(1, 1, 0, 1);
        total++;
        if (bcd4 !== 16'h0000 || run4 !== 1'b0) begin
            bad++;
            $display("FAIL edge_discarded: bcd=%h run=%b want 0000/0", bcd4, run4);
        end
    endtask

    task automatic test_reset_mid();
        restart();
        for (int i = 0; i < 250; i++) cyc(1, 0, 0, 1);
        total++;
        if (bcd4 !== 16'h0250) begin
            bad++;
            $display("FAIL preset_250: bcd=%h want 0250", bcd4);
        end
        cyc(1, 1, 0, 0);
        total++;
        if (bcd4 !== 16'h0000 || ovf4 !== 1'b0 || run4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: bcd=%h ovf=%b run=%b want 0000/0/0", bcd4, ovf4, run4);
        end
    endtask

    task automatic test_random();
        bit ss;
        ss = start_stop;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ss = ~ss;
            cyc(1'($urandom_range(0, 1)), ss, ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 299) != 0));
            total++;
            if (bcd4 !== to_bcd(m_cnt4) || bcd2 !== to_bcd(m_cnt2) ||
                run4 !== (m_mode == 1) || run2 !== (m_mode == 1) ||
                ovf4 !== m_ovf4 || ovf2 !== m_ovf2) begin
                bad++;
                $display("FAIL random[%0d]: got bcd4=%h bcd2=%h run=%b/%b ovf=%b/%b want %h %h %b %b/%b",
                         i, bcd4, bcd2, run4, run2, ovf4, ovf2, to_bcd(m_cnt4),
                         to_bcd(m_cnt2)[7:0], (m_mode == 1), m_ovf4, m_ovf2);
            end
        end
    endtask

    // long enough wrap run for the 4-digit instance: tick held high every cycle
    task automatic test_back_to_back();
        restart();
        for (int i = 0; i < 9999; i++) cyc(1, 0, 0, 1);
        total++;
        if (bcd4 !== 16'h9999 || ovf4 !== 1'b0) begin
            bad++;
            $display("FAIL preset_9999: bcd=%h ovf=%b want 9999/0", bcd4, ovf4);
        end
        cyc(1, 0, 0, 1);
        total++;
        if (bcd4 !== 16'h0000 || ovf4 !== 1'b1 || run4 !== 1'b1) begin
            bad++;
            $display("FAIL wrap4: bcd=%h ovf=%b run=%b want 0000/1/1", bcd4, ovf4, run4);
        end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_count_pause();
        test_wrap();
        test_same_cycle();
        test_clear_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
